uart_rx_unit: RTL
=================

Name: uart_rx_unit

Overview:
- Serial receive front end that feeds the MIPS DataPath debug/loader logic.
- Recovers bytes from the asynchronous `rx` line using 16x oversampling from an internal baud tick generator.
- Presents each byte on a valid/ready handshake with a one-byte holding register.
- Reports overrun and framing errors as sticky flags.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 19200, line baud rate.
- DBIT, 8, data bits per frame, LSB first.
- SB_TICK, 16, oversample ticks in the stop bit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- err_clr  input  1  one-cycle pulse clears overrun and frame_err.
- rx_data  output  DBIT  received byte.
- rx_valid  output  1  rx_data holds an unaccepted byte.
- overrun  output  1  sticky: a byte was lost.
- frame_err  output  1  sticky: stop bit sampled low.

Behaviour:
- Reset (reset=0, async): all registers clear; rx synchroniser flops reset to 1; state IDLE; rx_data=0, rx_valid=0, overrun=0, frame_err=0; tick divider=0.
- Synchroniser: 2-flop on rx; all decisions use the synchronised value rxs.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*16), integer division.
  - Counter counts 0..DIV-1 and emits a one-clk `tick` at DIV-1, then wraps to 0.
  - Counter free-runs.
- State machine (sample counter s 0..15, bit counter n 0..DBIT-1):
  - IDLE: on rxs==0, go to START with s=0.
  - START: on tick with s==7:
    - If rxs==0 (mid start bit): go to DATA with s=0, n=0.
    - Else (glitch): return to IDLE.
  - DATA: on tick with s==15, shift rxs into the MSB of the shift register (shift right) and set s=0. If n==DBIT-1 go to STOP, else n++.
  - STOP: on tick with s==SB_TICK-1, evaluate the stop bit:
    - If rxs==1: deliver the byte and go to IDLE.
    - If rxs==0: set frame_err, discard the byte, go to BRK.
  - BRK: wait for rxs==1, then go to IDLE. A line held low (break or power-up low) never produces repeated frames.
  - Otherwise, on each tick s increments.
- Delivery (cycle after the stop sample):
  - If rx_valid==0, or rx_valid&&rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - Otherwise keep the old rx_data and set overrun=1.
- Handshake:
  - rx_valid&&rx_ready with no simultaneous delivery clears rx_valid next cycle.
  - rx_data stays stable while rx_valid=1.
- err_clr clears both sticky flags. If a new error occurs in the same cycle as err_clr, the set wins.
- Latency: rx_valid rises at most DIV*16*(DBIT+1.5)+DIV+3 clks after the falling start edge at the pin.
- Reset mid-frame aborts the frame; no partial byte is delivered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - One even-parity bit is received after the data bits, in a PAR state using the same 16-tick bit timing.
  - Adds output parity_err (1 bit, sticky, cleared by err_clr, reset 0).
  - A parity mismatch sets parity_err; the byte is still delivered if the stop bit is good.
- When undefined: no PAR state, no parity_err port, frame = start + DBIT + stop.

Decomposition:
- Package uart_pkg holds:
  - State encoding: IDLE, START, DATA, STOP, BRK, PAR.
  - OVS=16 constant.
  - A function computing DIV from CLK_HZ and BAUD.
- One sub-module: uart_baud_gen (tick counter, parameter DIV, outputs `tick`). The FSM, synchroniser and holding register stay in uart_rx_unit.

Test Plan:
1. CLK_HZ=1600000, BAUD=10000 (DIV=10, bit=160 clk); send 0xA5 with rx_ready=0 -> rx_data=0xA5, rx_valid=1 within 1533 clk of start edge; stays 1 until rx_ready pulse, then 0 next cycle.
2. Send 0x3C then 0x81 without accepting -> rx_data=0x3C, overrun=1; err_clr pulse -> overrun=0, rx_data still 0x3C.
3. Accept 0x3C in the exact cycle 0x81 delivers -> rx_data=0x81, rx_valid stays 1, overrun=0.
4. Hold rx=0 from reset release for 3000 clk -> frame_err=1 once, rx_valid=0, no further frames; raise rx, send 0x55 -> received correctly.
5. 40-clk low glitch on idle line -> state returns IDLE, no rx_valid, no frame_err.
6. Drive reset=0 mid-byte (after 4 data bits) -> all outputs 0 immediately; next full 0xF0 frame received intact. With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err=1, rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK,
    PAR
  } rx_state_t;

  localparam int unsigned OVS = 16;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OVS);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-clk tick every DIV clocks.
module uart_baud_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 16x oversampling UART receiver with one-byte holding register and sticky errors.
// Optional even-parity reception is enabled by defining UART_RX_PARITY_EN.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 19200,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            rx_ready,
  input  logic            err_clr,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  output logic            overrun,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned NW  = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned SW  = (SB_TICK > OVS) ? $clog2(SB_TICK) : $clog2(OVS);

  logic            rx_meta;
  logic            rxs;
  logic            tick;
  rx_state_t       state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] sh, sh_n;
  logic            stop_ok;
  logic            frame_set;
  logic            dlv;
`ifdef UART_RX_PARITY_EN
  logic            par_set;
`endif

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      sh    <= '0;
      dlv   <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      sh    <= sh_n;
      dlv   <= stop_ok;
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = s;
    n_n       = n;
    sh_n      = sh;
    stop_ok   = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == SW'(OVS / 2 - 1)) begin
            if (!rxs) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == SW'(OVS - 1)) begin
            s_n  = '0;
            sh_n = {rxs, sh[DBIT-1:1]};
            if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PAR;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (tick) begin
          if (s == SW'(OVS - 1)) begin
            s_n     = '0;
            par_set = (rxs != ^sh);
            state_n = STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            stop_ok   = rxs;
            frame_set = !rxs;
            state_n   = rxs ? IDLE : BRK;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      // A low line after a bad stop bit must go high before a new start is accepted.
      BRK: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // sh is untouched in IDLE/START, so it still holds the frame on the delivery cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (dlv && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (dlv && rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (frame_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (par_set) begin
      parity_err <= 1'b1;
    end else if (err_clr) begin
      parity_err <= 1'b0;
    end
  end
`endif

endmodule
